// File: rtl/four_bit_piso_tx_if.sv
// Handshake and serial-stream bundle for the PISO transmitter.
// master drives words in and watches the stream; slave is the transmitter.
interface four_bit_piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/four_bit_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready capture and frame markers.
// Define PIPO_TX_PARITY_EN to append an even-parity bit to every frame.
//
// state  | meaning
// IDLE   | no frame, ready for a word
// SHIFT  | sending data bits, counter selects frame position
// PARITY | sending the even-parity bit (PIPO_TX_PARITY_EN only)
module four_bit_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             reset,
  four_bit_piso_tx_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PIPO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             head_bit;
  logic             accept;
  logic             ready_c, out_c, valid_c, first_c, last_c;
`ifdef PIPO_TX_PARITY_EN
  logic             par;
`endif

  assign cnt_last = (cnt == CNT_LAST);
  assign head_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign accept   = bus.in_valid && ready_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    ready_c = 1'b0;
    out_c   = 1'b0;
    valid_c = 1'b0;
    first_c = 1'b0;
    last_c  = 1'b0;
    case (state)
      IDLE: ready_c = 1'b1;
      SHIFT: begin
        valid_c = 1'b1;
        out_c   = head_bit;
        first_c = (cnt == '0);
`ifdef PIPO_TX_PARITY_EN
        if (cnt_last) state_d = PARITY;
`else
        ready_c = cnt_last;
        last_c  = cnt_last;
        if (cnt_last) state_d = IDLE;
`endif
      end
`ifdef PIPO_TX_PARITY_EN
      PARITY: begin
        valid_c = 1'b1;
        out_c   = par;
        last_c  = 1'b1;
        ready_c = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // a word accepted on the final cycle restarts the frame with no gap
    if (bus.in_valid && ready_c) state_d = SHIFT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
`ifdef PIPO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      shreg <= bus.in_data;
      cnt   <= '0;
`ifdef PIPO_TX_PARITY_EN
      par   <= ^bus.in_data;
`endif
    end else if (state == SHIFT) begin
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      cnt   <= cnt_last ? '0 : cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.ser_out   = out_c;
  assign bus.ser_valid = valid_c;
  assign bus.ser_first = first_c;
  assign bus.ser_last  = last_c;
  assign bus.busy      = valid_c;
endmodule

// File: tb/tb_four_bit_piso_tx.sv
// Scoreboard bench for four_bit_piso_tx: an MSB-first and an LSB-first instance.
// Expected bits are queued on each accept and popped by a negedge monitor.
module tb_four_bit_piso_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  four_bit_piso_tx_if #(.WIDTH(4)) bm ();
  four_bit_piso_tx_if #(.WIDTH(4)) bl ();

  four_bit_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bm.slave));
  four_bit_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl.slave));

  typedef struct packed {logic b; logic f; logic l;} exp_t;
  exp_t q[2][$];
  int tests = 0;
  int fails = 0;

  task automatic push_frame(input int k, input logic [3:0] w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b = (k == 0) ? w[3-i] : w[i];
      e.f = (i == 0);
      e.l = (i == 3);
`ifdef PIPO_TX_PARITY_EN
      e.l = 1'b0;
`endif
      q[k].push_back(e);
    end
`ifdef PIPO_TX_PARITY_EN
    e.b = ^w;
    e.f = 1'b0;
    e.l = 1'b1;
    q[k].push_back(e);
`endif
  endtask

  // in_ready is expected high exactly on the frame's final cycle
  task automatic mon(input int k, input logic v, input logic o, input logic f,
                     input logic l, input logic r, input logic b);
    exp_t e;
    logic [4:0] got, want;
    if (q[k].size() > 0 || v) begin
      tests++;
      if (!v) begin
        fails++;
        $display("FAIL bubble dut%0d: ser_valid=0 required 1 (%0d bits pending)", k, q[k].size());
      end else if (q[k].size() == 0) begin
        fails++;
        $display("FAIL unexpected dut%0d: ser_valid=1 ser_out=%b required no frame", k, o);
      end else begin
        e = q[k].pop_front();
        got  = {o, f, l, r, b};
        want = {e.b, e.f, e.l, e.l, 1'b1};
        if (got !== want) begin
          fails++;
          $display("FAIL bit dut%0d out/first/last/ready/busy=%b required %b", k, got, want);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready, bm.busy);
      mon(1, bl.ser_valid, bl.ser_out, bl.ser_first, bl.ser_last, bl.in_ready, bl.busy);
    end
  end

  task automatic set_in(input int k, input logic [3:0] w, input logic v);
    if (k == 0) begin bm.in_data = w; bm.in_valid = v; end
    else        begin bl.in_data = w; bl.in_valid = v; end
  endtask

  task automatic send(input int k, input logic [3:0] w);
    int n = 0;
    @(negedge clk);
    set_in(k, w, 1'b1);
    while (!((k == 0) ? bm.in_ready : bl.in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL send_timeout dut%0d word=%b: in_ready=0 required 1 within 50 cycles", k, w);
    end else begin
      @(posedge clk);
      push_frame(k, w);
    end
  endtask

  task automatic drop(input int k);
    @(negedge clk);
    if (k == 0) bm.in_valid = 1'b0;
    else        bl.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 40) begin
      fails++;
      $display("FAIL drain: %0d/%0d bits still pending required 0/0", q[0].size(), q[1].size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string name, input int k);
    logic [5:0] got;
    if (k == 0) got = {bm.in_ready, bm.ser_out, bm.ser_valid, bm.ser_first, bm.ser_last, bm.busy};
    else        got = {bl.in_ready, bl.ser_out, bl.ser_valid, bl.ser_first, bl.ser_last, bl.busy};
    tests++;
    if (got !== 6'b100000) begin
      fails++;
      $display("FAIL %s dut%0d ready/out/valid/first/last/busy=%b required 100000", name, k, got);
    end
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 4'b0000, 1'b0);
    set_in(1, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset", 0);
    check_idle("reset", 1);
    @(negedge clk);
    reset = 1'b1;

    // basic MSB-first
    send(0, 4'b1010);
    drop(0);
    drain();

    // back-to-back: second word waits for the final-cycle ready
    send(0, 4'b1010);
    send(0, 4'b0101);
    drop(0);
    drain();

    // word offered mid-frame is ignored
    send(0, 4'b1100);
    @(negedge clk);
    @(negedge clk);
    set_in(0, 4'b0011, 1'b1);
    tests++;
    if (bm.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ignored_ready: in_ready=%b required 0", bm.in_ready);
    end
    @(negedge clk);
    bm.in_valid = 1'b0;
    drain();

    // reset mid-frame
    send(0, 4'b1111);
    drop(0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    q[0].delete();
    #1;
    check_idle("reset_midframe", 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_idle("after_reset", 0);

    // LSB-first instance
    send(1, 4'b0001);
    drop(1);
    drain();

    // frame whose parity bit is 1 when parity is enabled
    send(0, 4'b1011);
    drop(0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/four_bit_piso_tx.md
Name: four_bit_piso_tx

Overview:
- Parallel-in, serial-out transmitter: the read-out counterpart of the 4-bit parallel register.
- Captures a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock, with frame markers.
- Sits between the 4-bit register output and any serial sink (a SIPO receiver or an off-chip pin).

Parameters:
- WIDTH, 4, word width in bits; legal range 2..16.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  transmitter can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_first  output  1  first bit of the frame.
- ser_last  output  1  final bit of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; shift register and bit counter clear.
  - Outputs: in_ready=1, ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
  - Reset asserted mid-frame aborts the frame immediately. No partial bits are sent after release.
- States:
  - IDLE -> SHIFT on accept. Accept means in_valid && in_ready at a rising edge.
  - SHIFT -> IDLE after the final bit, unless a new word is accepted on that same edge. In that case stay in SHIFT and restart the frame.
  - PARITY state is present only with the optional feature.
- Capture:
  - On accept, in_data is latched into the internal shift register and the bit counter is loaded with 0.
  - Changes on in_data after accept have no effect on the frame in flight.
- Latency: the first bit appears on ser_out, with ser_valid=1 and ser_first=1, in the cycle after the accept edge.
- Bit order:
  - MSB_FIRST=1: bit WIDTH-1 down to bit 0.
  - MSB_FIRST=0: bit 0 up to bit WIDTH-1.
  - One bit per clock, with ser_valid held high for all WIDTH cycles.
- Counter: counts 0..WIDTH-1. ser_last=1 while the counter equals WIDTH-1 and no parity bit follows.
- in_ready:
  - High in IDLE.
  - High during the cycle carrying the last bit of the frame; this allows back-to-back frames with no gap.
  - Low during all other frame cycles.
  - in_valid asserted while in_ready=0 is ignored, not queued.
- busy: high whenever ser_valid is high. Outside a frame, ser_out is driven 0.
- Back-to-back: with continuous valid words, ser_valid stays high without a bubble. ser_first asserts on the cycle immediately after ser_last.

Optional Feature:
- Macro: PIPO_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra PARITY cycle sends the even-parity bit, i.e. the XOR of the latched word.
  - ser_valid=1 during the parity cycle; ser_last moves to the parity cycle.
  - in_ready is high during the parity cycle and not during the last data bit.
  - Frame length is WIDTH+1.
- Undefined: there is no PARITY state, and the frame is WIDTH bits exactly.

Test Plan:
- Basic MSB-first:
  - Stimulus: reset low for 2 cycles, release; send 4'b1010 with in_valid for 1 cycle.
  - Required: ser_out=1,0,1,0 on the next 4 cycles; ser_first on bit 1; ser_last on bit 4; in_ready=1 again from bit 4.
- Back-to-back:
  - Stimulus: in_valid held high with 4'b1010, then 4'b0101 accepted on the last-bit cycle.
  - Required: 8 consecutive ser_valid cycles, ser_out=1,0,1,0,0,1,0,1; ser_first at cycles 1 and 5.
- Ignored input:
  - Stimulus: accept 4'b1100; during bit 2, drive in_data=4'b0011 with in_valid=1.
  - Required: stream stays 1,1,0,0; second word is not accepted until in_ready=1.
- Reset mid-frame:
  - Stimulus: accept 4'b1111; assert reset during bit 2 (between clock edges).
  - Required: ser_valid, busy and ser_out drop to 0 immediately; after release in_ready=1 and no stale bits appear.
- LSB-first (MSB_FIRST=0):
  - Stimulus: send 4'b0001.
  - Required: ser_out=1,0,0,0.
- Parity (PIPO_TX_PARITY_EN defined):
  - Stimulus: send 4'b1011.
  - Required: ser_out=1,0,1,1 then parity 1; ser_last only on the 5th bit; frame is 5 valid cycles.
